mem_bus_responder: RTL
======================

Name: mem_bus_responder

Overview:
- Board-side responder for the CPU's byte-wide memory bus.
- Serves RAM reads and writes with 1-cycle read latency through an external synchronous RAM macro.
- Decodes the I/O window (bus_a[17:16]==2'b11):
  - UART TX byte queue with io_buffer_full back-pressure.
  - UART RX byte read.
  - Cycle-counter read.
  - Program-stop write.
- Sits between the CPU core and the RAM macro / UART in the top level.

Parameters:
- RAM_AW, 17, RAM byte-address width (128 KB).
- TX_DEPTH, 8, TX FIFO entries; power of two, >=4.
- FULL_MARGIN, 2, io_buffer_full asserts when free TX slots <= FULL_MARGIN. This covers CPU writes already in flight.

Ports:
- clk_in, in, 1, system clock.
- rst_in, in, 1, reset, asynchronous, active-high.
- rdy_in, in, 1, bus qualifier; when low the block is frozen.
- bus_a, in, 32, CPU address; only [17:0] decoded.
- bus_wr, in, 1, 1 = write, 0 = read.
- bus_wdata, in, 8, CPU write byte.
- bus_rdata, out, 8, read byte, valid the cycle after the request.
- io_buffer_full, out, 1, TX FIFO nearly full.
- ram_a, out, RAM_AW, RAM address (comb = bus_a[RAM_AW-1:0]).
- ram_we, out, 1, RAM write enable (comb).
- ram_wdata, out, 8, RAM write byte (comb = bus_wdata).
- ram_rdata, in, 8, RAM read byte; sync, 1-cycle latency.
- tx_data, out, 8, UART TX byte (FIFO head).
- tx_valid, out, 1, FIFO non-empty.
- tx_ready, in, 1, UART accepts head this cycle.
- rx_data, in, 8, UART RX byte.
- rx_valid, in, 1, RX byte available.
- rx_pop, out, 1, registered 1-cycle pulse; consumes RX byte.
- program_stop, out, 1, sticky; program finished and TX drained.
- tx_overflow, out, 1, sticky; a push hit a full FIFO.

Behaviour:
- Reset values: bus_rdata=0, io_buffer_full=0, tx_valid=0, tx_data=0, rx_pop=0, program_stop=0, tx_overflow=0. FIFO empty, cycle counter=0, snapshot=0, stop_pending=0.
- io = (bus_a[17:16]==2'b11). ram_we = rdy_in & bus_wr & ~io.
- Read latency is exactly 1 cycle. On a read at cycle N, the block registers a source select (RAM or IO) plus any IO byte. bus_rdata at N+1 = ram_rdata if RAM, else the registered IO byte. When no read is accepted, bus_rdata holds its previous value.
- IO read 0x30000: returns rx_data if rx_valid, else 0x00. rx_pop=1 at N+1 only if rx_valid was 1.
- IO read 0x30004..0x30007: byte (addr[1:0]) of a 32-bit snapshot, little-endian.
  - A read of 0x30004 (offset 0) reloads the snapshot from the live counter, and returns byte0 of the live value.
  - Offsets 1..3 read the held snapshot, so the 4 bytes are coherent.
- Other IO addresses: read 0x00; writes ignored.
- IO write 0x30000: push bus_wdata into the TX FIFO unless it is 0x00 (ignored).
- IO write 0x30004:
  - Push 0x00 (this write is never ignored) and set stop_pending.
  - program_stop rises the cycle after stop_pending=1 and the FIFO is empty.
  - Both stay high until reset.
- Push into a full FIFO: byte dropped, tx_overflow set; count unchanged.
- Simultaneous push and pop (tx_valid & tx_ready) with FIFO full: the pop frees a slot, so the push is accepted.
- Pointers are log2(TX_DEPTH)+1 bits with wrap. tx_data/tx_valid reflect the head combinationally from registered state.
- io_buffer_full is registered from the next-state count: (TX_DEPTH - count_next) <= FULL_MARGIN.
- Cycle counter: 32-bit, increments every cycle rdy_in=1, wraps at 2^32.
- rdy_in=0 freezes all of the following: no RAM write, no FIFO push, no rx_pop, counter held, bus_rdata held.
  - The TX pop side still drains: the UART is independent of CPU pause.
- Async reset mid-operation clears everything immediately. A partially drained FIFO is discarded.

Decomposition:
- Shared package constants:
  - IO_SEL (2'b11 on addr[17:16]).
  - IO_PORT_UART (2'h0 on addr[2:0]).
  - IO_PORT_CLK (3'h4).
  - STOP_BYTE (8'h00).
- One sub-module: tx_byte_fifo (parameter DEPTH; push/pop/full/empty/count; async reset).

Test Plan:
- Write 0xA5 to 0x00123, then read 0x00123 -> ram_we=1 with ram_a=0x0123; the next-cycle read gives bus_rdata=0xA5 exactly one cycle after the request.
- Write 0x48, 0x00, 0x69 to 0x30000 with tx_ready=0 -> FIFO count=2. Asserting tx_ready then gives tx_data 0x48 then 0x69, then tx_valid=0.
- TX_DEPTH=8, FULL_MARGIN=2, tx_ready=0, six pushes -> io_buffer_full=1 after the 6th. The 9th push sets tx_overflow and the FIFO holds the first 8.
- After 1000 cycles with rdy_in=1, read 0x30004..0x30007 on consecutive cycles -> bytes of 1000 (0xE8,0x03,0x00,0x00) despite the counter advancing. rdy_in=0 for 10 cycles -> counter unchanged.
- rx_valid=1, rx_data=0x37, read 0x30000 -> bus_rdata=0x37 and rx_pop pulse one cycle. Repeat with rx_valid=0 -> 0x00, no pulse.
- Push 0x41, then write 0x30004 with tx_ready=0 -> program_stop stays 0. Then tx_ready=1 drains 0x41, 0x00, and program_stop=1 the cycle after empty. Assert rst_in mid-drain -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/mem_bus_responder_pkg.sv
// Shared constants and types for the CPU memory-bus responder: I/O window select,
// I/O port offsets, the stop marker byte and the read-source / port decode helper.
package mem_bus_responder_pkg;

  localparam logic [1:0] IO_SEL       = 2'b11;
  localparam logic [2:0] IO_PORT_UART = 3'h0;
  localparam logic [2:0] IO_PORT_CLK  = 3'h4;
  localparam logic [7:0] STOP_BYTE    = 8'h00;

  typedef enum logic {
    SRC_RAM = 1'b0,
    SRC_IO  = 1'b1
  } rd_src_e;

  typedef enum logic [1:0] {
    PORT_NONE = 2'd0,
    PORT_UART = 2'd1,
    PORT_CLK  = 2'd2
  } io_port_e;

  // Only the low 8 bytes of the window are populated; the clock port spans 4 bytes.
  function automatic io_port_e decode_port(input logic [15:0] off);
    if (off[15:3] != '0)
      return PORT_NONE;
    else if (off[2:0] == IO_PORT_UART)
      return PORT_UART;
    else if (off[2] == IO_PORT_CLK[2])
      return PORT_CLK;
    else
      return PORT_NONE;
  endfunction

endpackage

// File: rtl/tx_byte_fifo.sv
// Byte FIFO feeding the UART transmitter; head is visible combinationally (0-cycle).
// A push into a full FIFO is dropped unless a pop frees a slot in the same cycle.
module tx_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [7:0]                 push_data,
  input  logic                       pop,
  output logic [7:0]                 pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic [$clog2(DEPTH):0]     count_next,
  output logic                       push_drop
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic [7:0]  mem [DEPTH];
  logic        pop_ok;
  logic        push_ok;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count = wptr - rptr;

  assign pop_ok    = pop & ~empty;
  assign push_ok   = push & (~full | pop_ok);
  assign push_drop = push & ~push_ok;

  assign count_next = count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};

  // Head reads as zero when empty so the output is clean straight out of reset.
  assign pop_data = empty ? 8'h00 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/mem_bus_responder.sv
// Board-side responder for the byte-wide CPU bus: RAM pass-through plus I/O window.
// Read data 1 cycle after request; io_buffer_full throttles the CPU before the TX FIFO fills.
module mem_bus_responder
  import mem_bus_responder_pkg::*;
#(
  parameter int RAM_AW      = 17,
  parameter int TX_DEPTH    = 8,
  parameter int FULL_MARGIN = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic [31:0]       bus_a,
  input  logic              bus_wr,
  input  logic [7:0]        bus_wdata,
  output logic [7:0]        bus_rdata,
  output logic              io_buffer_full,
  output logic [RAM_AW-1:0] ram_a,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_pop,
  output logic              program_stop,
  output logic              tx_overflow
);

  localparam int CW = $clog2(TX_DEPTH) + 1;

  logic        io;
  io_port_e    port;
  logic        rd_req;
  logic        wr_io;
  logic        rd_uart;
  logic        rd_clk;
  logic        is_stop;
  logic        push;
  logic [7:0]  push_data;
  logic [7:0]  io_byte;

  logic        rd_vld_q;
  rd_src_e     rd_src_q;
  logic [7:0]  io_byte_q;
  logic [7:0]  rdata_hold;
  logic [31:0] cyc_cnt;
  logic [31:0] snapshot;
  logic        stop_pending;

  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_cnt;
  logic [CW-1:0] fifo_cnt_next;
  logic          fifo_drop;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^{bus_a[31:18], fifo_full, fifo_cnt};

  assign io   = (bus_a[17:16] == IO_SEL);
  assign port = decode_port(bus_a[15:0]);

  assign ram_a     = bus_a[RAM_AW-1:0];
  assign ram_wdata = bus_wdata;
  assign ram_we    = rdy_in & bus_wr & ~io;

  assign rd_req  = rdy_in & ~bus_wr;
  assign wr_io   = rdy_in & bus_wr & io;
  assign rd_uart = rd_req & io & (port == PORT_UART);
  assign rd_clk  = rd_req & io & (port == PORT_CLK);
  assign is_stop = (port == PORT_CLK) && (bus_a[1:0] == 2'b00);

  // A zero byte to the UART port is filtered; the stop write always enqueues its marker.
  assign push      = wr_io & (((port == PORT_UART) && (bus_wdata != STOP_BYTE)) || is_stop);
  assign push_data = is_stop ? STOP_BYTE : bus_wdata;

  // Offset 0 of the clock port returns the live count; it is also what gets snapshotted.
  always_comb begin
    io_byte = 8'h00;
    if (rd_uart) begin
      io_byte = rx_valid ? rx_data : 8'h00;
    end else if (rd_clk) begin
      if (bus_a[1:0] == 2'b00)
        io_byte = cyc_cnt[7:0];
      else
        io_byte = snapshot[{bus_a[1:0], 3'b000} +: 8];
    end
  end

  assign bus_rdata = rd_vld_q ? ((rd_src_q == SRC_RAM) ? ram_rdata : io_byte_q) : rdata_hold;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rd_vld_q       <= 1'b0;
      rd_src_q       <= SRC_RAM;
      io_byte_q      <= 8'h00;
      rdata_hold     <= 8'h00;
      rx_pop         <= 1'b0;
      cyc_cnt        <= 32'd0;
      snapshot       <= 32'd0;
      stop_pending   <= 1'b0;
      program_stop   <= 1'b0;
      tx_overflow    <= 1'b0;
      io_buffer_full <= 1'b0;
    end else begin
      rd_vld_q   <= rd_req;
      rdata_hold <= bus_rdata;
      if (rd_req) begin
        rd_src_q  <= io ? SRC_IO : SRC_RAM;
        io_byte_q <= io_byte;
      end
      rx_pop <= rd_uart & rx_valid;
      if (rdy_in) cyc_cnt <= cyc_cnt + 32'd1;
      if (rd_clk && (bus_a[1:0] == 2'b00)) snapshot <= cyc_cnt;
      if (wr_io && is_stop) stop_pending <= 1'b1;
      if (stop_pending && fifo_empty) program_stop <= 1'b1;
      if (fifo_drop) tx_overflow <= 1'b1;
      io_buffer_full <= (TX_DEPTH - int'(fifo_cnt_next)) <= FULL_MARGIN;
    end
  end

  tx_byte_fifo #(
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk        (clk_in),
    .rst        (rst_in),
    .push       (push),
    .push_data  (push_data),
    .pop        (tx_ready),
    .pop_data   (tx_data),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_cnt),
    .count_next (fifo_cnt_next),
    .push_drop  (fifo_drop)
  );

  assign tx_valid = ~fifo_empty;

endmodule
